// File: rtl/sclk_note_player.sv
// Timed square-wave note player: accepts {half-period, duration} by valid/ready,
// plays the tone for dur ticks, inserts a silent gap, then pulses note_done.
//
// state | meaning
// IDLE  | waiting for a note, note_ready high
// PLAY  | toggling sclk every mc_r+1 cycles, counting dur_r ticks down
// GAP   | sclk held low, counting GAP_TICKS ticks down
module sclk_note_player #(
    parameter int TICK_DIV  = 100000,
    parameter int GAP_TICKS = 10
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic [15:0] note_maxcount,
    input  logic [7:0]  note_dur,
    input  logic        note_valid,
    output logic        note_ready,
    output logic        sclk,
    output logic        busy,
    output logic        note_done
);

    localparam int PW = $clog2(TICK_DIV);
    localparam int GW = $clog2(GAP_TICKS + 2);
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
    localparam logic [GW-1:0] GAP_LOAD   = GW'(GAP_TICKS);

    typedef enum logic [1:0] {IDLE, PLAY, GAP} state_t;

    state_t        state;
    logic [15:0]   mc_r;
    logic [15:0]   hp_cnt;
    logic [7:0]    dur_r;
    logic [PW-1:0] presc;
    logic [GW-1:0] gap_cnt;
    logic          tick;

    assign tick       = (presc == PRESC_LAST);
    assign note_ready = (state == IDLE);
    assign busy       = (state != IDLE);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state     <= IDLE;
            mc_r      <= '0;
            hp_cnt    <= '0;
            dur_r     <= '0;
            presc     <= '0;
            gap_cnt   <= '0;
            sclk      <= 1'b0;
            note_done <= 1'b0;
        end else begin
            note_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (note_valid) begin
                        mc_r    <= note_maxcount;
                        dur_r   <= note_dur;
                        hp_cnt  <= '0;
                        presc   <= '0;
                        gap_cnt <= GAP_LOAD;
                        sclk    <= 1'b0;
                        if (note_dur != 8'd0) begin
                            state <= PLAY;
                        end else if (GAP_TICKS != 0) begin
                            state <= GAP;
                        end else begin
                            state     <= IDLE;
                            note_done <= 1'b1;
                        end
                    end
                end
                PLAY: begin
                    presc <= tick ? '0 : presc + 1'b1;
                    if (mc_r == 16'd0) begin
                        hp_cnt <= '0;
                        sclk   <= 1'b0;
                    end else if (hp_cnt == mc_r) begin
                        hp_cnt <= '0;
                        sclk   <= ~sclk;
                    end else begin
                        hp_cnt <= hp_cnt + 16'd1;
                    end
                    if (tick) begin
                        dur_r <= dur_r - 8'd1;
                        if (dur_r == 8'd1) begin
                            // last tick of the note: silence wins over any pending toggle
                            sclk    <= 1'b0;
                            hp_cnt  <= '0;
                            presc   <= '0;
                            gap_cnt <= GAP_LOAD;
                            if (GAP_TICKS != 0) begin
                                state <= GAP;
                            end else begin
                                state     <= IDLE;
                                note_done <= 1'b1;
                            end
                        end
                    end
                end
                GAP: begin
                    presc <= tick ? '0 : presc + 1'b1;
                    sclk  <= 1'b0;
                    if (tick) begin
                        gap_cnt <= gap_cnt - 1'b1;
                        if (gap_cnt == GW'(1)) begin
                            state     <= IDLE;
                            note_done <= 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sclk_note_player.sv
// Directed bench for sclk_note_player with TICK_DIV=10, GAP_TICKS=2.
// Cycle numbering: cycle 1 is the first cycle after the accepting edge.
module tb_sclk_note_player;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic [15:0] note_maxcount = '0;
    logic [7:0]  note_dur = '0;
    logic        note_valid = 1'b0;
    logic        note_ready, sclk, busy, note_done;

    int passed = 0;
    int total  = 0;

    logic sclk_h  [0:127];
    logic done_h  [0:127];
    logic busy_h  [0:127];
    logic ready_h [0:127];

    sclk_note_player #(.TICK_DIV(10), .GAP_TICKS(2)) dut (
        .CLK(CLK), .RST(RST),
        .note_maxcount(note_maxcount), .note_dur(note_dur), .note_valid(note_valid),
        .note_ready(note_ready), .sclk(sclk), .busy(busy), .note_done(note_done)
    );

    always #5 CLK = ~CLK;

    // Called #1 after a rising edge while idle; the next edge accepts.
    task automatic send_note(input logic [15:0] mc, input logic [7:0] d);
        note_maxcount = mc;
        note_dur      = d;
        note_valid    = 1'b1;
        @(posedge CLK); #1;
        note_valid    = 1'b0;
    endtask

    task automatic capture(input int n);
        sclk_h[0] = 1'b0;
        for (int c = 1; c <= n; c++) begin
            sclk_h[c]  = sclk;
            done_h[c]  = note_done;
            busy_h[c]  = busy;
            ready_h[c] = note_ready;
            @(posedge CLK); #1;
        end
    endtask

    function automatic int first_high(input int lo, input int hi);
        for (int c = lo; c <= hi; c++) if (sclk_h[c] === 1'b1) return c;
        return -1;
    endfunction

    function automatic int count_rises(input int lo, input int hi);
        int n = 0;
        for (int c = lo; c <= hi; c++) if (sclk_h[c] === 1'b1 && sclk_h[c-1] !== 1'b1) n++;
        return n;
    endfunction

    function automatic int count_high(input int lo, input int hi);
        int n = 0;
        for (int c = lo; c <= hi; c++) if (sclk_h[c] !== 1'b0) n++;
        return n;
    endfunction

    function automatic int first_done(input int lo, input int hi);
        for (int c = lo; c <= hi; c++) if (done_h[c] === 1'b1) return c;
        return -1;
    endfunction

    function automatic int count_done(input int lo, input int hi);
        int n = 0;
        for (int c = lo; c <= hi; c++) if (done_h[c] !== 1'b0) n++;
        return n;
    endfunction

    task automatic test_reset();
        int dev = 0;
        @(posedge CLK); #1;
        total++;
        if ({sclk, note_ready, busy, note_done} !== 4'b0100)
            $display("FAIL reset_in_reset: got sclk/ready/busy/done=%b want 0100", {sclk, note_ready, busy, note_done});
        else passed++;
        RST = 1'b0;
        for (int c = 0; c < 50; c++) begin
            @(posedge CLK); #1;
            if ({sclk, note_ready, busy, note_done} !== 4'b0100) dev++;
        end
        total++;
        if (dev !== 0) $display("FAIL reset_idle_50: %0d deviating cycles, want 0", dev);
        else passed++;
    endtask

    task automatic test_tone();
        int ch_prev = -1;
        int bad_space = 0;
        int nbusy = 0;
        send_note(16'd3, 8'd4);
        capture(70);
        total++;
        if (ready_h[1] !== 1'b0) $display("FAIL tone_ready_c1: got %b want 0", ready_h[1]);
        else passed++;
        // hp_cnt matches 3 during cycle 4, so the rising edge ending cycle 4 raises sclk
        total++;
        if (first_high(1, 40) !== 5) $display("FAIL tone_first_high: got %0d want 5", first_high(1, 40));
        else passed++;
        total++;
        if (count_rises(1, 40) !== 5) $display("FAIL tone_pulses: got %0d want 5", count_rises(1, 40));
        else passed++;
        for (int c = 2; c <= 40; c++) begin
            if (sclk_h[c] !== sclk_h[c-1]) begin
                if (ch_prev >= 0 && c - ch_prev != 4) bad_space++;
                ch_prev = c;
            end
        end
        total++;
        if (bad_space !== 0 || ch_prev !== 37)
            $display("FAIL tone_spacing: bad=%0d last_toggle=%0d want 0 and 37", bad_space, ch_prev);
        else passed++;
        total++;
        if (count_high(41, 60) !== 0) $display("FAIL tone_gap_silent: got %0d high cycles want 0", count_high(41, 60));
        else passed++;
        for (int c = 1; c <= 60; c++) if (busy_h[c] === 1'b1) nbusy++;
        total++;
        if (nbusy !== 60 || busy_h[61] !== 1'b0) $display("FAIL tone_busy: got %0d busy cycles, busy61=%b want 60,0", nbusy, busy_h[61]);
        else passed++;
        total++;
        if (first_done(1, 70) !== 61 || count_done(1, 70) !== 1)
            $display("FAIL tone_done: got first=%0d count=%0d want 61,1", first_done(1, 70), count_done(1, 70));
        else passed++;
    endtask

    task automatic test_rest_and_zero();
        send_note(16'd0, 8'd3);
        capture(60);
        total++;
        if (count_high(1, 60) !== 0) $display("FAIL rest_silent: got %0d high cycles want 0", count_high(1, 60));
        else passed++;
        total++;
        if (first_done(1, 60) !== 51) $display("FAIL rest_done: got %0d want 51", first_done(1, 60));
        else passed++;
        send_note(16'd5, 8'd0);
        capture(30);
        total++;
        if (count_high(1, 30) !== 0 || busy_h[1] !== 1'b1)
            $display("FAIL zero_dur_silent: got highs=%0d busy1=%b want 0,1", count_high(1, 30), busy_h[1]);
        else passed++;
        total++;
        if (first_done(1, 30) !== 21) $display("FAIL zero_dur_done: got %0d want 21", first_done(1, 30));
        else passed++;
    endtask

    task automatic test_back_to_back();
        int nready = 0;
        int waited = 0;
        note_maxcount = 16'd1;
        note_dur      = 8'd1;
        note_valid    = 1'b1;
        @(posedge CLK); #1;
        note_maxcount = 16'd2;
        note_dur      = 8'd1;
        capture(80);
        note_valid = 1'b0;
        for (int c = 1; c <= 61; c++) if (ready_h[c] === 1'b1) nready++;
        total++;
        if (nready !== 1 || ready_h[31] !== 1'b1)
            $display("FAIL b2b_ready: got %0d ready cycles, ready31=%b want 1,1", nready, ready_h[31]);
        else passed++;
        total++;
        if (done_h[31] !== 1'b1 || busy_h[32] !== 1'b1)
            $display("FAIL b2b_handoff: got done31=%b busy32=%b want 1,1", done_h[31], busy_h[32]);
        else passed++;
        total++;
        if (first_high(1, 31) !== 3 || first_high(32, 41) !== 35)
            $display("FAIL b2b_first_high: got A=%0d B=%0d want 3,35", first_high(1, 31), first_high(32, 41));
        else passed++;
        total++;
        if (first_done(32, 80) !== 62) $display("FAIL b2b_done_b: got %0d want 62", first_done(32, 80));
        else passed++;
        while (note_done !== 1'b1 && waited < 100) begin
            @(posedge CLK); #1;
            waited++;
        end
        total++;
        if (note_done !== 1'b1) $display("FAIL b2b_drain_timeout: note_done=%b after %0d cycles want 1", note_done, waited);
        else passed++;
        @(posedge CLK); #1;
    endtask

    task automatic test_input_hold();
        int r1, r2;
        note_maxcount = 16'd3;
        note_dur      = 8'd2;
        note_valid    = 1'b1;
        @(posedge CLK); #1;
        note_valid = 1'b0;
        sclk_h[0] = 1'b0;
        for (int c = 1; c <= 50; c++) begin
            if (c == 5) begin
                note_maxcount = 16'd9;
                note_dur      = 8'd7;
            end
            sclk_h[c] = sclk;
            done_h[c] = note_done;
            busy_h[c] = busy;
            @(posedge CLK); #1;
        end
        r1 = first_high(1, 20);
        r2 = -1;
        for (int c = r1 + 1; c <= 20; c++)
            if (r2 < 0 && sclk_h[c] === 1'b1 && sclk_h[c-1] === 1'b0) r2 = c;
        total++;
        if (r1 !== 5 || r2 !== 13) $display("FAIL hold_period: got rises %0d,%0d want 5,13", r1, r2);
        else passed++;
        total++;
        if (count_high(21, 40) !== 0 || busy_h[40] !== 1'b1)
            $display("FAIL hold_play_len: got gap highs=%0d busy40=%b want 0,1", count_high(21, 40), busy_h[40]);
        else passed++;
        total++;
        if (first_done(1, 50) !== 41) $display("FAIL hold_done: got %0d want 41", first_done(1, 50));
        else passed++;
    endtask

    task automatic test_reset_mid_note();
        send_note(16'd3, 8'd4);
        repeat (12) begin
            @(posedge CLK); #1;
        end
        total++;
        if (sclk !== 1'b1) $display("FAIL midrst_pre_sclk: got %b want 1", sclk);
        else passed++;
        RST = 1'b1;
        #1;
        total++;
        if ({sclk, note_ready, busy} !== 3'b010)
            $display("FAIL midrst_async: got sclk/ready/busy=%b want 010", {sclk, note_ready, busy});
        else passed++;
        @(posedge CLK); #1;
        RST = 1'b0;
        capture(70);
        total++;
        if (count_done(1, 70) !== 0 || count_high(1, 70) !== 0)
            $display("FAIL midrst_no_done: got done=%0d highs=%0d want 0,0", count_done(1, 70), count_high(1, 70));
        else passed++;
        send_note(16'd1, 8'd1);
        capture(40);
        total++;
        if (first_high(1, 10) !== 3 || count_rises(1, 10) !== 2)
            $display("FAIL midrst_replay_tone: got first=%0d rises=%0d want 3,2", first_high(1, 10), count_rises(1, 10));
        else passed++;
        total++;
        if (first_done(1, 40) !== 31) $display("FAIL midrst_replay_done: got %0d want 31", first_done(1, 40));
        else passed++;
    endtask

    initial begin
        test_reset();
        test_tone();
        test_rest_and_zero();
        test_back_to_back();
        test_input_hold();
        test_reset_mid_note();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/sclk_note_player.md
# sclk_note_player

Timed tone generator that consumes the 16-bit half-period count (`maxcount`) produced by the switch/note decoders and turns it into the speaker square wave `sclk`. It accepts one note per valid/ready handshake as {half-period count, duration}, plays it for an exact number of millisecond ticks, inserts a fixed silent gap, then signals completion. It sits between a note source (decoder or sequencer ROM) and the speaker output pin.

## Interface
- `TICK_DIV`, 100000: clock cycles per duration tick (1 ms at 100 MHz); must be ≥ 2.
- `GAP_TICKS`, 10: silent ticks inserted after every note; 0 means no gap.
- `CLK`  in  1  system clock; all state changes on the rising edge.
- `RST`  in  1  asynchronous, active-high reset.
- `note_maxcount`  in  16  half-period count; 0 means rest (silence).
- `note_dur`  in  8  note duration in ticks; 0 means no tone, gap only.
- `note_valid`  in  1  note source has a note on `note_maxcount`/`note_dur`.
- `note_ready`  out  1  high when the block is in IDLE and can accept a note.
- `sclk`  out  1  square-wave output to the speaker, registered.
- `busy`  out  1  high in PLAY or GAP.
- `note_done`  out  1  one-cycle pulse when a note, including its gap, has finished.

## Operation
- States: IDLE, PLAY, GAP. `note_ready` = (state == IDLE). `busy` = (state != IDLE).
- Accept happens on the rising edge where `note_valid && note_ready`. On accept:
  - latch `note_maxcount` into `mc_r` and `note_dur` into `dur_r`;
  - clear the half-period counter and tick prescaler;
  - go to PLAY if `note_dur` ≠ 0; otherwise go to GAP, or to IDLE if GAP_TICKS = 0.
- Input changes after accept are ignored until the next accept.
- Tick prescaler counts 0..TICK_DIV−1 in PLAY and GAP. A tick fires on the wrap and the count restarts at 0 on every state entry.
- PLAY:
  - `hp_cnt` (16-bit) increments each cycle.
  - When `hp_cnt == mc_r`: `hp_cnt` ← 0 and `sclk` toggles. Half period is therefore `mc_r + 1` cycles.
  - If `mc_r == 0`, `sclk` is held 0 and `hp_cnt` is held 0.
  - `dur_r` decrements on each tick. On the tick where `dur_r == 1`, PLAY ends and the next state is GAP, or IDLE if GAP_TICKS = 0.
- GAP: `sclk` = 0; a gap counter counts GAP_TICKS ticks, then the next state is IDLE.
- On every transition into IDLE that ends a note, `note_done` = 1 for exactly that first IDLE cycle.
- Leaving PLAY forces `sclk` to 0 on the same edge. This overrides a toggle scheduled on that edge.
- Counter widths: `hp_cnt` 16 bits, compare-and-clear, never wraps. Prescaler is sized $clog2(TICK_DIV). `dur_r` is 8 bits.

## Timing
- Reset (async, immediate): state IDLE, `sclk` 0, `note_done` 0, `busy` 0, `note_ready` 1; all counters 0.
- Accept at edge E0. The first PLAY cycle follows E0, and `note_ready` is 0 in that cycle.
- PLAY occupies exactly `note_dur`·TICK_DIV cycles, GAP occupies exactly GAP_TICKS·TICK_DIV cycles, and `note_done` is high in the next cycle.
- The first `sclk` rise occurs `mc_r + 1` cycles into PLAY.
- Back-to-back: a note presented with `note_valid` during the `note_done` cycle is accepted on that edge. There are no idle cycles between notes.
- `RST` asserted mid-PLAY or mid-GAP aborts the note: `sclk` goes to 0 immediately and no `note_done` is generated.

## Test plan
All scenarios use TICK_DIV = 10 and GAP_TICKS = 2.
- Reset release: check `sclk` = 0, `note_ready` = 1, `busy` = 0, `note_done` = 0; with `note_valid` = 0 for 50 cycles, check no change.
- Tone: maxcount = 3, dur = 4.
  - Check `sclk` toggles every 4 cycles, first rise at PLAY cycle 4, 5 high pulses in 40 PLAY cycles.
  - Check `sclk` = 0 for GAP cycles 41–60 and `note_done` pulses in cycle 61.
- Rest and zero duration:
  - maxcount = 0, dur = 3: check `sclk` = 0 throughout and `note_done` in cycle 51.
  - maxcount = 5, dur = 0: check no toggles and `note_done` in cycle 21.
- Back-to-back: hold `note_valid` = 1 and present note A (maxcount = 1, dur = 1), then note B (maxcount = 2, dur = 1) in A's `note_done` cycle; check B's first PLAY cycle directly follows, with 1 cycle of `note_ready` = 1.
- Input hold: after accepting maxcount = 3, dur = 2, change inputs to maxcount = 9, dur = 7 mid-note; check the period stays 8 cycles and PLAY stays 20 cycles.
- Reset mid-note: assert `RST` at PLAY cycle 13 of maxcount = 3, dur = 4.
  - Check `sclk` = 0 asynchronously, state IDLE, and no `note_done`.
  - After release, accept maxcount = 1, dur = 1 and check correct playback.
